// File: rtl/cen_sequencer_sync.sv
// Multi-channel clock-enable sequencer: per-channel divided square-wave Cen outputs
// with phase preload, wrap-synchronous divisor updates and an orderly drain on Stop.
module cen_sequencer_sync #(
  parameter int CHANNELS = 4,
  parameter int DIVW     = 8
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic                     Stop,
  input  logic [CHANNELS*DIVW-1:0] Div,
  input  logic [CHANNELS*DIVW-1:0] Phase,
  output logic [CHANNELS-1:0]      Cen,
  output logic [CHANNELS-1:0]      Tick,
  output logic                     Running,
  output logic                     Busy,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t state;

  logic [DIVW-1:0]     div_a   [CHANNELS];
  logic [DIVW-1:0]     phase_a [CHANNELS];
  logic [DIVW-1:0]     s_q     [CHANNELS];
  logic [DIVW-1:0]     c_q     [CHANNELS];
  logic [DIVW-1:0]     s_n     [CHANNELS];
  logic [DIVW-1:0]     c_n     [CHANNELS];
  logic [CHANNELS-1:0] frz_q;
  logic [CHANNELS-1:0] frz_n;
  logic [CHANNELS-1:0] cen_n;
  logic [CHANNELS-1:0] tick_n;
  logic                draining;

  genvar g;
  generate
    for (g = 0; g < CHANNELS; g++) begin : g_unpack
      assign div_a[g]   = Div[g*DIVW +: DIVW];
      assign phase_a[g] = Phase[g*DIVW +: DIVW];
    end
  endgenerate

  // High time of a period S+1 is ceil((S+1)/2); one extra bit keeps S = max from overflowing.
  function automatic logic [DIVW:0] high_len(input logic [DIVW-1:0] s);
    high_len = ({1'b0, s} + (DIVW+1)'(2)) >> 1;
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (Start && !Stop) state <= LOAD;
        LOAD:    state <= RUN;
        RUN:     if (Stop) state <= DRAIN;
        DRAIN:   if (&frz_q) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The Stop cycle in RUN already counts as the first drain step.
  assign draining = (state == DRAIN) || ((state == RUN) && Stop);

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      c_n[i]   = c_q[i];
      s_n[i]   = s_q[i];
      frz_n[i] = frz_q[i];
      case (state)
        IDLE: begin
          c_n[i]   = '0;
          frz_n[i] = 1'b0;
        end
        LOAD: begin
          s_n[i]   = div_a[i];
          c_n[i]   = (phase_a[i] > div_a[i]) ? '0 : phase_a[i];
          frz_n[i] = 1'b0;
        end
        default: begin
          if (draining) begin
            if (frz_q[i] || (s_q[i] == '0) || (c_q[i] == s_q[i])) begin
              c_n[i]   = '0;
              frz_n[i] = 1'b1;
            end else begin
              c_n[i] = c_q[i] + DIVW'(1);
            end
          end else if (c_q[i] == s_q[i]) begin
            c_n[i] = '0;
            s_n[i] = div_a[i];
          end else begin
            c_n[i] = c_q[i] + DIVW'(1);
          end
        end
      endcase
      cen_n[i]  = frz_n[i] || ({1'b0, c_n[i]} < high_len(s_n[i]));
      tick_n[i] = (state != IDLE) && Cen[i] && !cen_n[i];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        c_q[i] <= '0;
        s_q[i] <= '0;
      end
      frz_q <= '0;
      Cen   <= '1;
      Tick  <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        c_q[i] <= c_n[i];
        s_q[i] <= s_n[i];
      end
      frz_q <= frz_n;
      Cen   <= cen_n;
      Tick  <= tick_n;
    end
  end

  assign Running   = (state == RUN) || (state == DRAIN);
  assign Busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_cen_sequencer_sync.sv
// Bench for cen_sequencer_sync: vector table for the reference pattern, hand sequences
// for phase/divisor/stop/reset corners, and random runs against a period-level model.
module tb_cen_sequencer_sync;

  localparam int CH = 4;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic start;
  logic stop;
  logic [DW-1:0] div_v   [CH];
  logic [DW-1:0] phase_v [CH];
  logic [CH*DW-1:0] div_bus;
  logic [CH*DW-1:0] phase_bus;
  logic [CH-1:0] cen;
  logic [CH-1:0] tick;
  logic running;
  logic busy;
  logic [1:0] dbg_state;

  assign div_bus   = {div_v[3], div_v[2], div_v[1], div_v[0]};
  assign phase_bus = {phase_v[3], phase_v[2], phase_v[1], phase_v[0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cen_sequencer_sync #(.CHANNELS(CH), .DIVW(DW)) dut (
    .Clk(clk), .Reset(rst), .Start(start), .Stop(stop),
    .Div(div_bus), .Phase(phase_bus),
    .Cen(cen), .Tick(tick), .Running(running), .Busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (period/position view) ----------------
  localparam int MD_IDLE = 0, MD_LOAD = 1, MD_ACTIVE = 2, MD_STOP = 3;
  int mode;
  int pos  [CH];
  int per  [CH];
  bit done [CH];
  logic [CH-1:0] m_cen;
  logic [CH-1:0] m_tick;
  logic m_running;
  logic m_busy;

  task automatic model_reset();
    mode = MD_IDLE;
    for (int i = 0; i < CH; i++) begin
      pos[i] = 0; per[i] = 1; done[i] = 0;
    end
    m_cen = '1; m_tick = '0; m_running = 0; m_busy = 0;
  endtask

  task automatic drain_one(input int i);
    if (done[i] || per[i] == 1 || pos[i] == per[i] - 1) begin
      pos[i] = 0; done[i] = 1;
    end else begin
      pos[i]++;
    end
  endtask

  task automatic model_step();
    logic [CH-1:0] prev;
    int ndone;
    prev = m_cen;
    case (mode)
      MD_IDLE: if (start && !stop) mode = MD_LOAD;
      MD_LOAD: begin
        for (int i = 0; i < CH; i++) begin
          per[i]  = int'(div_v[i]) + 1;
          pos[i]  = (phase_v[i] > div_v[i]) ? 0 : int'(phase_v[i]);
          done[i] = 0;
        end
        mode = MD_ACTIVE;
      end
      MD_ACTIVE: begin
        if (stop) begin
          mode = MD_STOP;
          for (int i = 0; i < CH; i++) drain_one(i);
        end else begin
          for (int i = 0; i < CH; i++) begin
            if (pos[i] == per[i] - 1) begin
              pos[i] = 0; per[i] = int'(div_v[i]) + 1;
            end else begin
              pos[i]++;
            end
          end
        end
      end
      default: begin
        ndone = 0;
        for (int i = 0; i < CH; i++) if (done[i]) ndone++;
        if (ndone == CH) begin
          mode = MD_IDLE;
          for (int i = 0; i < CH; i++) pos[i] = 0;
        end else begin
          for (int i = 0; i < CH; i++) drain_one(i);
        end
      end
    endcase
    for (int i = 0; i < CH; i++) begin
      m_cen[i]  = done[i] || (pos[i] < (per[i] + 1) / 2);
      m_tick[i] = (mode == MD_ACTIVE || mode == MD_STOP) && prev[i] && !m_cen[i];
    end
    m_running = (mode == MD_ACTIVE || mode == MD_STOP);
    m_busy    = (mode != MD_IDLE);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("cen", cen, m_cen);
    check("tick", tick, m_tick);
    check("running", running, m_running);
    check("busy", busy, m_busy);
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100 && m_busy; n++) step();
    check("idle_reached", busy, 0);
  endtask

  task automatic run_len(input logic val, output int n);
    n = 0;
    while (cen[0] === val && n < 20) begin
      n++;
      step();
    end
  endtask

  task automatic set_divs(input int d0, d1, d2, d3);
    div_v[0] = DW'(d0); div_v[1] = DW'(d1); div_v[2] = DW'(d2); div_v[3] = DW'(d3);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          start;
    logic          stop;
    logic [CH-1:0] cen;
    logic [CH-1:0] tick;
    logic          running;
    logic          busy;
  } vec_t;
  vec_t tbl [20];

  task automatic set_vec(input int k, input logic st, sp, input logic [3:0] c, t,
                         input logic r, b);
    tbl[k] = '{st, sp, c, t, r, b};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    start = 0; stop = 0; rst = 1;
    set_divs(0, 0, 0, 0);
    for (int i = 0; i < CH; i++) phase_v[i] = '0;
    model_reset();

    // reset state
    #1;
    check("rst_cen", cen, 4'hF);
    check("rst_tick", tick, 0);
    check("rst_running", running, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    step();

    // Div={3,1,0,4}, Phase=0: reference pattern, then Stop with ch0 at C=1, ch3 at C=3
    set_vec(0,  1, 0, 4'b1111, 4'b0000, 0, 1);
    set_vec(1,  0, 0, 4'b1111, 4'b0000, 1, 1);
    set_vec(2,  0, 0, 4'b1101, 4'b0010, 1, 1);
    set_vec(3,  0, 0, 4'b1110, 4'b0001, 1, 1);
    set_vec(4,  0, 0, 4'b0100, 4'b1010, 1, 1);
    set_vec(5,  0, 0, 4'b0111, 4'b0000, 1, 1);
    set_vec(6,  0, 0, 4'b1101, 4'b0010, 1, 1);
    set_vec(7,  0, 0, 4'b1110, 4'b0001, 1, 1);
    set_vec(8,  0, 0, 4'b1100, 4'b0010, 1, 1);
    set_vec(9,  0, 0, 4'b0111, 4'b1000, 1, 1);
    set_vec(10, 0, 0, 4'b0101, 4'b0010, 1, 1);
    set_vec(11, 0, 0, 4'b1110, 4'b0001, 1, 1);
    set_vec(12, 0, 0, 4'b1100, 4'b0010, 1, 1);
    set_vec(13, 0, 0, 4'b1111, 4'b0000, 1, 1);
    set_vec(14, 0, 0, 4'b0101, 4'b1010, 1, 1);
    set_vec(15, 0, 1, 4'b0110, 4'b0001, 1, 1);
    set_vec(16, 0, 0, 4'b1110, 4'b0000, 1, 1);
    set_vec(17, 0, 0, 4'b1111, 4'b0000, 1, 1);
    set_vec(18, 0, 0, 4'b1111, 4'b0000, 0, 0);
    set_vec(19, 1, 1, 4'b1111, 4'b0000, 0, 0);
    set_divs(3, 1, 0, 4);
    for (int k = 0; k < 20; k++) begin
      start = tbl[k].start; stop = tbl[k].stop;
      step();
      start = 0; stop = 0;
      check($sformatf("tbl%0d_cen", k), cen, tbl[k].cen);
      check($sformatf("tbl%0d_tick", k), tick, tbl[k].tick);
      check($sformatf("tbl%0d_running", k), running, tbl[k].running);
      check($sformatf("tbl%0d_busy", k), busy, tbl[k].busy);
    end

    // phase preload: Phase=2 lands low with a Tick; Phase>Div loads 0
    set_divs(3, 0, 0, 0);
    phase_v[0] = 8'd2;
    pulse_start(); step();
    check("ph2_cen0", cen[0], 0);
    check("ph2_tick0", tick[0], 1);
    pulse_stop(); wait_idle();
    phase_v[0] = 8'd9;
    pulse_start(); step();
    check("ph9_cen0", cen[0], 1);
    check("ph9_tick0", tick[0], 0);
    step(); step();
    check("ph9_cen0_c2", cen[0], 0);
    check("ph9_tick0_c2", tick[0], 1);
    pulse_stop(); wait_idle();

    // divisor change mid-period takes effect only at wrap
    phase_v[0] = 8'd0;
    pulse_start(); step();
    div_v[0] = 8'd5;
    run_len(1'b1, n); check("div_hi_old", n, 2);
    run_len(1'b0, n); check("div_lo_old", n, 2);
    run_len(1'b1, n); check("div_hi_new", n, 3);
    run_len(1'b0, n); check("div_lo_new", n, 3);
    pulse_stop(); wait_idle();

    // Start during DRAIN is ignored
    set_divs(3, 1, 0, 4);
    pulse_start();
    for (int k = 0; k < 6; k++) step();
    pulse_stop();
    pulse_start();
    wait_idle();
    step();
    check("drain_start_ignored", busy, 0);

    // asynchronous reset mid-RUN, then restart from Phase
    phase_v[0] = 8'd1; phase_v[3] = 8'd2;
    pulse_start();
    for (int k = 0; k < 5; k++) step();
    #3 rst = 1;
    #1;
    check("arst_cen", cen, 4'hF);
    check("arst_tick", tick, 0);
    check("arst_busy", busy, 0);
    check("arst_running", running, 0);
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    step(); step();
    pulse_start();
    for (int k = 0; k < 12; k++) step();
    pulse_stop(); wait_idle();

    // random runs against the model
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < CH; i++) begin
        div_v[i]   = ($urandom_range(0, 3) == 0) ? 8'd0 : DW'($urandom_range(1, 12));
        phase_v[i] = DW'($urandom_range(0, 14));
      end
      if ($urandom_range(0, 1) == 1) begin
        start = 1; stop = 1; step(); start = 0; stop = 0;
      end
      pulse_start();
      step();
      for (int k = 0; k < int'($urandom_range(8, 60)); k++) begin
        if ($urandom_range(0, 7) == 0) begin
          n = $urandom_range(0, CH - 1);
          if (div_v[n] != 0) div_v[n] = DW'($urandom_range(1, 12));
        end
        start = ($urandom_range(0, 9) == 0);
        step();
        start = 0;
      end
      pulse_stop();
      for (int k = 0; k < 3; k++) begin
        start = $urandom_range(0, 1);
        stop  = $urandom_range(0, 1);
        step();
      end
      start = 0; stop = 0;
      wait_idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
